reg_file_2r1w: RTL and testbench

- 32 x 32-bit general-purpose register file for the datapath.
- Two registered read ports feed the operand-select muxes downstream.
- One write port is driven by writeback.
- Per-register busy scoreboard flags pending writes, so issue logic can stall on RAW hazards.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_read_port.sv | 54 +++++
 rtl/reg_file_2r1w.sv | 90 +++++++++
 tb/tb_reg_file_2r1w.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing, address/word types and the hardwired-zero register index
// for the 2-read/1-write register file.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_word_t;

    localparam reg_addr_t ZERO_REG = '0;

    // Register 0 is hardwired, so it can never be written or claimed
    function automatic logic is_writable(input reg_addr_t addr);
        return addr != ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: selects data and busy for its address and holds
// them until the next read. REGFILE_BYPASS_EN forwards same-edge writeback data.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en,
    input  reg_addr_t           addr,
    input  reg_word_t           regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy_vec,
    input  logic                wr_en,
    input  reg_addr_t           wr_addr,
    input  reg_word_t           wr_data,
    input  logic                claim_en,
    input  reg_addr_t           claim_addr,
    output reg_word_t           rd_data,
    output logic                rd_busy
);

    reg_word_t sel_data;
    logic      sel_busy;

`ifdef REGFILE_BYPASS_EN
    // A colliding write clears busy unless the same edge re-claims the register
    always_comb begin
        sel_data = regs[addr];
        sel_busy = busy_vec[addr];
        if (wr_en && wr_addr == addr && is_writable(addr)) begin
            sel_data = wr_data;
            sel_busy = claim_en && (claim_addr == addr);
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, wr_addr, wr_data, claim_en, claim_addr};

    always_comb begin
        sel_data = regs[addr];
        sel_busy = busy_vec[addr];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (rd_en) begin
            rd_data <= sel_data;
            rd_busy <= sel_busy;
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32x32 register file with two registered read ports, one writeback port and
// a per-register busy scoreboard for RAW stalls. Optional macro: REGFILE_BYPASS_EN.
module reg_file_2r1w
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en,
    input  reg_addr_t           rs1_addr,
    input  reg_addr_t           rs2_addr,
    output reg_word_t           rs1_data,
    output reg_word_t           rs2_data,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic                rd_valid,
    input  logic                wr_en,
    input  reg_addr_t           wr_addr,
    input  reg_word_t           wr_data,
    input  logic                claim_en,
    input  reg_addr_t           claim_addr,
    output logic [NUM_REGS-1:0] busy_vec
);

    reg_word_t regs [NUM_REGS];

    // Entry 0 is reset to zero and never written, so reads of it return 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (wr_en && is_writable(wr_addr)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A claim beats a same-edge write: the new producer is still outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (claim_en && claim_addr == reg_addr_t'(i)) begin
                    busy_vec[i] <= 1'b1;
                end else if (wr_en && wr_addr == reg_addr_t'(i)) begin
                    busy_vec[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
        end
    end

    regfile_read_port u_rs1_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .addr       (rs1_addr),
        .regs       (regs),
        .busy_vec   (busy_vec),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_data    (rs1_data),
        .rd_busy    (rs1_busy)
    );

    regfile_read_port u_rs2_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .addr       (rs2_addr),
        .regs       (regs),
        .busy_vec   (busy_vec),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_data    (rs2_data),
        .rd_busy    (rs2_busy)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: a behavioural register/busy model produces
// expected read results, queued at drive time and popped after the edge.
module tb_reg_file_2r1w;
    import regfile_pkg::*;

    typedef struct {
        reg_word_t d1;
        reg_word_t d2;
        logic      b1;
        logic      b2;
    } rd_exp_t;

    logic                clk;
    logic                rst_n;
    logic                rd_en;
    reg_addr_t           rs1_addr;
    reg_addr_t           rs2_addr;
    reg_word_t           rs1_data;
    reg_word_t           rs2_data;
    logic                rs1_busy;
    logic                rs2_busy;
    logic                rd_valid;
    logic                wr_en;
    reg_addr_t           wr_addr;
    reg_word_t           wr_data;
    logic                claim_en;
    reg_addr_t           claim_addr;
    logic [NUM_REGS-1:0] busy_vec;

    int errors = 0;
    int checks = 0;

    reg_word_t           m_regs [NUM_REGS];
    logic [NUM_REGS-1:0] m_busy;
    rd_exp_t             sb [$];
    rd_exp_t             held;
    logic                exp_valid;

    reg_file_2r1w dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rd_valid   (rd_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .busy_vec   (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_busy    = '0;
        sb.delete();
        held      = '{d1: '0, d2: '0, b1: 1'b0, b2: 1'b0};
        exp_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        if (exp_valid) begin
            if (sb.size() == 0) begin
                check({tag, ".sb_empty"}, 32'd0, 32'd1);
            end else begin
                held = sb.pop_front();
            end
        end
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_valid));
        check({tag, ".rs1_data"}, rs1_data, held.d1);
        check({tag, ".rs2_data"}, rs2_data, held.d2);
        check({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(held.b1));
        check({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(held.b2));
        check({tag, ".busy_vec"}, busy_vec, m_busy);
    endtask

    // Drive one cycle of inputs, queue the expected read, clock, update model, check
    task automatic applyStimulus(input logic rd, input reg_addr_t a1, input reg_addr_t a2,
                                 input logic we, input reg_addr_t wa, input reg_word_t wd,
                                 input logic ce, input reg_addr_t ca, input string tag);
        rd_exp_t e;
        rd_en = rd; rs1_addr = a1; rs2_addr = a2;
        wr_en = we; wr_addr = wa; wr_data = wd;
        claim_en = ce; claim_addr = ca;
        e.d1 = m_regs[a1]; e.b1 = m_busy[a1];
        e.d2 = m_regs[a2]; e.b2 = m_busy[a2];
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a1 && a1 != 0) begin e.d1 = wd; e.b1 = ce && ca == a1; end
        if (we && wa == a2 && a2 != 0) begin e.d2 = wd; e.b2 = ce && ca == a2; end
`endif
        if (rd) sb.push_back(e);
        @(posedge clk);
        #1;
        if (we && wa != 0) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (ce && ca != 0) m_busy[ca] = 1'b1;
        exp_valid = rd;
        checkOutput(tag);
    endtask

    initial begin
        modelReset();
        rst_n = 1'b0;
        rd_en = 1'b0; rs1_addr = '0; rs2_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        claim_en = 1'b0; claim_addr = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset");
        #3 rst_n = 1'b1;

        applyStimulus(1, 5'd5, 5'd31, 0, 5'd0, 32'h0, 0, 5'd0, "rd_after_reset");
        applyStimulus(0, 5'd0, 5'd0, 1, 5'd7, 32'hDEADBEEF, 0, 5'd0, "wr7");
        applyStimulus(1, 5'd7, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, "rd7_0");
        applyStimulus(0, 5'd0, 5'd0, 1, 5'd0, 32'h1234, 0, 5'd0, "wr0");
        applyStimulus(1, 5'd0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, "rd0");
        applyStimulus(0, 5'd0, 5'd0, 1, 5'd9, 32'h11, 0, 5'd0, "wr9_old");
        applyStimulus(1, 5'd9, 5'd9, 1, 5'd9, 32'hA5A5A5A5, 0, 5'd0, "collide9");
        applyStimulus(1, 5'd9, 5'd9, 0, 5'd0, 32'h0, 0, 5'd0, "rd9_new");
        applyStimulus(0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 1, 5'd12, "claim12");
        applyStimulus(1, 5'd12, 5'd7, 0, 5'd0, 32'h0, 0, 5'd0, "rd12_busy");
        applyStimulus(0, 5'd0, 5'd0, 1, 5'd12, 32'h55, 0, 5'd0, "wr12_clear");
        applyStimulus(0, 5'd0, 5'd0, 1, 5'd12, 32'h66, 1, 5'd12, "claim_wr12");
        applyStimulus(1, 5'd12, 5'd12, 0, 5'd0, 32'h0, 0, 5'd0, "rd12_claimed");
        applyStimulus(0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 1, 5'd0, "claim0");
        applyStimulus(0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 1, 5'd12, "reclaim12");
        applyStimulus(1, 5'd12, 5'd3, 1, 5'd12, 32'h77, 0, 5'd0, "collide12_busy");
        applyStimulus(0, 5'd0, 5'd0, 1, 5'd20, 32'h20, 0, 5'd0, "wr20_notbusy");
        applyStimulus(1, 5'd20, 5'd12, 0, 5'd0, 32'h0, 0, 5'd0, "pulse_rd");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 5'd1, 5'd2, 0, 5'd0, 32'h0, 0, 5'd0, "idle_hold");
        end

        applyStimulus(0, 5'd0, 5'd0, 1, 5'd3, 32'h33, 0, 5'd0, "wr3");
        applyStimulus(0, 5'd0, 5'd0, 1, 5'd4, 32'h44, 1, 5'd4, "wr4_claim4");
        applyStimulus(1, 5'd3, 5'd4, 0, 5'd0, 32'h0, 0, 5'd0, "rd3_4");
        rd_en = 1'b0; wr_en = 1'b0; claim_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        rd_en = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
        claim_en = 1'b1; claim_addr = 5'd6;
        @(posedge clk);
        #1;
        checkOutput("reset_held");
        rd_en = 1'b0; wr_en = 1'b0; claim_en = 1'b0;
        #3 rst_n = 1'b1;
        applyStimulus(1, 5'd3, 5'd4, 0, 5'd0, 32'h0, 0, 5'd0, "rd_after_async");
        applyStimulus(1, 5'd5, 5'd6, 0, 5'd0, 32'h0, 0, 5'd0, "rd_reset_ignored");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
